// File: rtl/core_sequencer_if.sv
// Instruction- and data-memory handshake bundle between core_sequencer (master)
// and the memory side (slave).
interface core_sequencer_if;
  logic        imem_req;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        memread;
  logic        memwrite;
  logic        mem_ack;

  modport master (
    output imem_req, memread, memwrite,
    input  imem_valid, imem_rdata, mem_ack
  );

  modport slave (
    input  imem_req, memread, memwrite,
    output imem_valid, imem_rdata, mem_ack
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/write-back control FSM for the datapath.
// Define SEQ_PERF_COUNTERS_EN to add the cycle_count / retired_count outputs.
module core_sequencer #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  core_sequencer_if.master bus,
  input  logic             start,
  input  logic             zero,
  input  logic             halt,
  output logic             ir_load,
  output logic [31:0]      instruction,
  output logic [31:0]      pc,
  output logic             regwr,
  output logic             busy,
  output logic             halted,
  output logic             illegal
`ifdef SEQ_PERF_COUNTERS_EN
  ,
  output logic [31:0]      cycle_count,
  output logic [31:0]      retired_count
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALTED
  } state_t;

  state_t      state, state_next;
  logic [1:0]  rst_sync;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, is_branch, is_jal, is_system, is_legal;
  logic        stop, taken;
  logic [31:0] imm_b, imm_j, pc_next;

  // Reset asserts asynchronously but is released two clocks later, in step with clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  assign opcode    = instruction[6:0];
  assign funct3    = instruction[14:12];
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_system = (opcode == OP_SYSTEM);
  assign is_legal  = (opcode == OP_R) || (opcode == OP_I) || is_load || is_store ||
                     is_jal || (opcode == OP_LUI) || (is_branch && funct3[2:1] == 2'b00);
  assign stop      = halt || is_system;
  assign taken     = funct3[0] ? !zero : zero;
  assign imm_b     = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
  assign imm_j     = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start) state_next = FETCH;
      FETCH:     if (bus.imem_valid) state_next = DECODE;
      DECODE:    state_next = (stop || !is_legal) ? HALTED : EXECUTE;
      EXECUTE: begin
        if (is_load || is_store) state_next = MEMORY;
        else if (is_branch)      state_next = FETCH;
        else                     state_next = WRITEBACK;
      end
      MEMORY:    if (bus.mem_ack) state_next = is_load ? WRITEBACK : FETCH;
      WRITEBACK: state_next = FETCH;
      HALTED:    state_next = HALTED;
      default:   state_next = IDLE;
    endcase
  end

  // Strobes decode the registered state only, so no input reaches an output combinationally.
  always_comb begin
    bus.imem_req = (state == FETCH);
    ir_load      = (state == DECODE);
    bus.memread  = (state == MEMORY) && is_load;
    bus.memwrite = (state == MEMORY) && is_store;
    regwr        = (state == WRITEBACK);
    busy         = (state != IDLE) && (state != HALTED);
    halted       = (state == HALTED);
  end

  always_comb begin
    pc_next = pc;
    case (state)
      EXECUTE: begin
        if (is_branch)   pc_next = taken ? pc + imm_b : pc + 32'd4;
        else if (is_jal) pc_next = pc + imm_j;
      end
      MEMORY:    if (bus.mem_ack && is_store) pc_next = pc + 32'd4;
      WRITEBACK: if (!is_jal) pc_next = pc + 32'd4;
      default:   pc_next = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= PC_RESET & 32'hFFFF_FFFC;
      instruction <= 32'h0;
      illegal     <= 1'b0;
    end else begin
      pc <= pc_next & 32'hFFFF_FFFC;
      if (state == FETCH && bus.imem_valid) instruction <= bus.imem_rdata;
      if (state == DECODE && !stop && !is_legal) illegal <= 1'b1;
    end
  end

`ifdef SEQ_PERF_COUNTERS_EN
  // Entering FETCH from IDLE is a start, not a retirement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count   <= 32'h0;
      retired_count <= 32'h0;
    end else begin
      if (busy) cycle_count <= cycle_count + 32'd1;
      if (state_next == FETCH && state != FETCH && state != IDLE)
        retired_count <= retired_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: instruction table driven through a scoreboard,
// plus hand-written halt, reset-during-stall and (optionally) performance-counter sequences.
module tb_core_sequencer;
  localparam logic [31:0] PC_RST = 32'h100;

  logic        clk = 1'b0;
  logic        rst, start, zero, halt;
  logic        ir_load, regwr, busy, halted, illegal;
  logic [31:0] instruction, pc;
`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] cycle_count, retired_count;
`endif
  int checks = 0;
  int failures = 0;

  core_sequencer_if bus();

  core_sequencer #(.PC_RESET(PC_RST)) dut (
    .clk(clk), .rst(rst), .bus(bus), .start(start), .zero(zero), .halt(halt),
    .ir_load(ir_load), .instruction(instruction), .pc(pc), .regwr(regwr),
    .busy(busy), .halted(halted), .illegal(illegal)
`ifdef SEQ_PERF_COUNTERS_EN
    , .cycle_count(cycle_count), .retired_count(retired_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        zero_in;
    logic        halt_in;
    int          imem_wait;
    int          mem_wait;
    int          exp_cycles;
    logic [31:0] exp_pc;
    int          exp_regwr;
    int          exp_memrd;
    int          exp_memwr;
    logic        exp_halted;
    logic        exp_illegal;
  } vec_t;

  typedef struct {
    int          idx;
    int          cycles;
    logic [31:0] pc;
    int          regwr;
    int          memrd;
    int          memwr;
    int          both;
    int          irl;
    logic [31:0] instr;
    logic        halted;
    logic        illegal;
    bit          timeout;
  } rec_t;

  rec_t exp_q[$];
  vec_t vecs[18];

  task automatic checkValue(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", what, act, exp);
    end
  endtask

  // Drives one instruction from FETCH until the next FETCH (or HALTED) and measures it.
  task automatic applyStimulus(input int idx, input vec_t v, output rec_t got);
    rec_t e;
    int   fwait = 0;
    int   mwait = 0;
    bit   loaded = 0;
    bit   done = 0;
    e = '{idx, v.exp_cycles, v.exp_pc, v.exp_regwr, v.exp_memrd, v.exp_memwr, 0, 1,
          v.instr, v.exp_halted, v.exp_illegal, 1'b0};
    exp_q.push_back(e);
    got = '{idx, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 1'b0, 1'b0, 1'b1};
    zero = v.zero_in;
    halt = v.halt_in;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if ((loaded && bus.imem_req) || halted) begin
        done = 1;
      end else begin
        got.cycles++;
        if (ir_load) begin
          got.irl++;
          loaded = 1;
          got.instr = instruction;
        end
        if (regwr) got.regwr++;
        if (bus.memread) got.memrd++;
        if (bus.memwrite) got.memwr++;
        if (bus.memread && bus.memwrite) got.both++;
        bus.imem_valid = bus.imem_req && (fwait >= v.imem_wait);
        bus.imem_rdata = bus.imem_valid ? v.instr : 32'hDEAD_BEEF;
        if (bus.imem_req) fwait++;
        bus.mem_ack = (bus.memread || bus.memwrite) && (mwait >= v.mem_wait);
        if (bus.memread || bus.memwrite) mwait++;
        @(negedge clk);
      end
    end
    got.timeout = !done;
    bus.imem_valid = 1'b0;
    bus.mem_ack = 1'b0;
    halt = 1'b0;
    got.pc = pc;
    got.halted = halted;
    got.illegal = illegal;
  endtask

  task automatic checkOutput(input rec_t got);
    rec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty: got result for v%0d expected none", got.idx);
    end else begin
      e = exp_q.pop_front();
      checkValue($sformatf("v%0d_timeout", e.idx), 32'(got.timeout), 32'(e.timeout));
      checkValue($sformatf("v%0d_cycles", e.idx), got.cycles, e.cycles);
      checkValue($sformatf("v%0d_pc", e.idx), got.pc, e.pc);
      checkValue($sformatf("v%0d_instr", e.idx), got.instr, e.instr);
      checkValue($sformatf("v%0d_ir_load", e.idx), got.irl, e.irl);
      checkValue($sformatf("v%0d_regwr", e.idx), got.regwr, e.regwr);
      checkValue($sformatf("v%0d_memread", e.idx), got.memrd, e.memrd);
      checkValue($sformatf("v%0d_memwrite", e.idx), got.memwr, e.memwr);
      checkValue($sformatf("v%0d_rdwr_both", e.idx), got.both, e.both);
      checkValue($sformatf("v%0d_halted", e.idx), 32'(got.halted), 32'(e.halted));
      checkValue($sformatf("v%0d_illegal", e.idx), 32'(got.illegal), 32'(e.illegal));
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    zero = 1'b0;
    halt = 1'b0;
    bus.imem_valid = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    checkValue("rst_pc", pc, PC_RST);
    checkValue("rst_instruction", instruction, 32'h0);
    checkValue("rst_strobes", 32'({bus.imem_req, ir_load, regwr, bus.memread, bus.memwrite}), 32'h0);
    checkValue("rst_flags", 32'({busy, halted, illegal}), 32'h0);
`ifdef SEQ_PERF_COUNTERS_EN
    checkValue("rst_cycle_count", cycle_count, 32'h0);
    checkValue("rst_retired_count", retired_count, 32'h0);
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkValue("idle_imem_req", 32'(bus.imem_req), 32'h0);
    checkValue("idle_busy", 32'(busy), 32'h0);
  endtask

  task automatic startRun();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkValue("fetch_after_start", 32'(bus.imem_req), 32'h1);
    checkValue("busy_after_start", 32'(busy), 32'h1);
  endtask

  task automatic checkAbsorbing(input int idx, input logic [31:0] exp_pc);
    int reqs = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) begin
      if (bus.imem_req) reqs++;
      @(negedge clk);
    end
    checkValue($sformatf("v%0d_halt_no_fetch", idx), reqs, 0);
    checkValue($sformatf("v%0d_halt_busy", idx), 32'(busy), 32'h0);
    checkValue($sformatf("v%0d_halt_sticky", idx), 32'(halted), 32'h1);
    checkValue($sformatf("v%0d_halt_pc", idx), pc, exp_pc);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rec_t got;
    int   waited;
    vec_t pv;

    //            instr          zero  halt  iw mw cyc pc         rw rd wr halted illegal
    vecs[0]  = '{32'h003100B3, 1'b0, 1'b0, 0, 0, 4, 32'h104, 1, 0, 0, 1'b0, 1'b0}; // add
    vecs[1]  = '{32'h0FC0006F, 1'b0, 1'b0, 0, 0, 4, 32'h200, 1, 0, 0, 1'b0, 1'b0}; // jal +0xFC
    vecs[2]  = '{32'h00000863, 1'b1, 1'b0, 0, 0, 3, 32'h210, 0, 0, 0, 1'b0, 1'b0}; // beq +16 taken
    vecs[3]  = '{32'h00001863, 1'b1, 1'b0, 0, 0, 3, 32'h214, 0, 0, 0, 1'b0, 1'b0}; // bne not taken
    vecs[4]  = '{32'hFE000CE3, 1'b1, 1'b0, 0, 0, 3, 32'h20C, 0, 0, 0, 1'b0, 1'b0}; // beq -8 taken
    vecs[5]  = '{32'h00001863, 1'b0, 1'b0, 0, 0, 3, 32'h21C, 0, 0, 0, 1'b0, 1'b0}; // bne +16 taken
    vecs[6]  = '{32'h00000863, 1'b0, 1'b0, 0, 0, 3, 32'h220, 0, 0, 0, 1'b0, 1'b0}; // beq not taken
    vecs[7]  = '{32'h123452B7, 1'b0, 1'b0, 0, 0, 4, 32'h224, 1, 0, 0, 1'b0, 1'b0}; // lui
    vecs[8]  = '{32'h00500093, 1'b0, 1'b0, 2, 0, 6, 32'h228, 1, 0, 0, 1'b0, 1'b0}; // addi, imem stall
    vecs[9]  = '{32'h00012083, 1'b0, 1'b0, 0, 3, 8, 32'h22C, 1, 4, 0, 1'b0, 1'b0}; // lw, ack late
    vecs[10] = '{32'h00012083, 1'b0, 1'b0, 0, 0, 5, 32'h230, 1, 1, 0, 1'b0, 1'b0}; // lw
    vecs[11] = '{32'h00112023, 1'b0, 1'b0, 0, 0, 4, 32'h234, 0, 0, 1, 1'b0, 1'b0}; // sw
    vecs[12] = '{32'h00112023, 1'b0, 1'b0, 0, 2, 6, 32'h238, 0, 0, 3, 1'b0, 1'b0}; // sw, ack late
    vecs[13] = '{32'hFFDFF0EF, 1'b0, 1'b0, 0, 0, 4, 32'h234, 1, 0, 0, 1'b0, 1'b0}; // jal -4
    vecs[14] = '{32'h00000073, 1'b0, 1'b0, 0, 0, 2, 32'h234, 0, 0, 0, 1'b1, 1'b0}; // ecall
    vecs[15] = '{32'h0000007F, 1'b0, 1'b0, 0, 0, 2, 32'h100, 0, 0, 0, 1'b1, 1'b1}; // bad opcode
    vecs[16] = '{32'h00002863, 1'b0, 1'b0, 0, 0, 2, 32'h100, 0, 0, 0, 1'b1, 1'b1}; // bad funct3
    vecs[17] = '{32'h003100B3, 1'b0, 1'b1, 0, 0, 2, 32'h100, 0, 0, 0, 1'b1, 1'b0}; // halt flag

    rst = 1'b1;
    start = 1'b0;
    zero = 1'b0;
    halt = 1'b0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.mem_ack = 1'b0;

    doReset();
    startRun();
    for (int i = 0; i < 18; i++) begin
      applyStimulus(i, vecs[i], got);
      checkOutput(got);
      if (vecs[i].exp_halted) begin
        checkAbsorbing(i, vecs[i].exp_pc);
        doReset();
        startRun();
      end
    end

    // Reset asserted while a load waits for mem_ack.
    bus.imem_rdata = 32'h00012083;
    bus.imem_valid = 1'b1;
    @(negedge clk);
    bus.imem_valid = 1'b0;
    waited = 0;
    while (!bus.memread && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checkValue("stall_reached_memory", 32'(bus.memread), 32'h1);
    repeat (2) @(negedge clk);
    checkValue("stall_memread_held", 32'(bus.memread), 32'h1);
    #2 rst = 1'b0;
    #1;
    checkValue("async_rst_strobes", 32'({bus.imem_req, ir_load, regwr, bus.memread, bus.memwrite}), 32'h0);
    checkValue("async_rst_flags", 32'({busy, halted, illegal}), 32'h0);
    checkValue("async_rst_pc", pc, PC_RST);
    checkValue("async_rst_instruction", instruction, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkValue("post_rst_idle_req", 32'(bus.imem_req), 32'h0);
    checkValue("post_rst_idle_busy", 32'(busy), 32'h0);
    startRun();

`ifdef SEQ_PERF_COUNTERS_EN
    doReset();
    startRun();
    for (int k = 0; k < 3; k++) begin
      pv = vecs[0];
      pv.exp_pc = PC_RST + 32'(4 * (k + 1));
      applyStimulus(100 + k, pv, got);
      checkOutput(got);
    end
    pv = vecs[14];
    pv.exp_pc = 32'h10C;
    applyStimulus(103, pv, got);
    checkOutput(got);
    checkValue("perf_retired", retired_count, 32'd3);
    checkValue("perf_cycles", cycle_count, 32'd14);
    repeat (5) @(negedge clk);
    checkValue("perf_retired_frozen", retired_count, 32'd3);
    checkValue("perf_cycles_frozen", cycle_count, 32'd14);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM that sequences the decoder/ALU/register-file/data-memory datapath: one instruction at a time through fetch, decode, execute, memory and write-back. Sits beside the datapath top level and drives its register-write, memory-read/write, instruction-register load and PC-update strobes. Handshakes with instruction memory and data memory, stalling on either, and stops permanently on a halt instruction or an illegal opcode.

## Interface
- `PC_RESET`, default 32'h0000_0000: PC value after reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  leave IDLE and begin fetching at PC.
- `imem_valid`  in  1  instruction memory has `imem_rdata` ready.
- `imem_rdata`  in  32  fetched instruction.
- `mem_ack`  in  1  data memory completed the current read/write.
- `zero`  in  1  ALU zero flag, sampled in EXECUTE.
- `halt`  in  1  decoder stop flag for the current instruction.
- `imem_req`  out  1  fetch request, held until `imem_valid`.
- `ir_load`  out  1  latch `imem_rdata` into instruction register.
- `instruction`  out  32  instruction register.
- `pc`  out  32  program counter (word aligned).
- `regwr`  out  1  register-file write enable.
- `memread`  out  1  data-memory read enable.
- `memwrite`  out  1  data-memory write enable.
- `busy`  out  1  not IDLE and not HALTED.
- `halted`  out  1  sticky stop indicator.
- `illegal`  out  1  sticky, set together with `halted` on an unknown opcode.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALTED.
- IDLE: `start`=1 -> FETCH.
- FETCH: `imem_req`=1; on `imem_valid` pulse `ir_load`, capture instruction -> DECODE.
- DECODE: opcode = `instruction[6:0]`. `halt`=1 or opcode 7'b1110011 -> HALTED. Unknown opcode -> HALTED with `illegal`=1. Otherwise -> EXECUTE.
- Legal opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (load), 0100011 (store), 1100011 (branch), 1101111 (jal), 0110111 (lui).
- EXECUTE: R/I-ALU/lui/jal -> WRITEBACK; load/store -> MEMORY; branch -> FETCH.
- Branch: funct3 000 (beq) taken when `zero`=1; 001 (bne) taken when `zero`=0; other funct3 is illegal (caught in DECODE). Taken: pc += B-immediate; else pc += 4.
- jal: pc += J-immediate on leaving EXECUTE; WRITEBACK writes old pc+4 (the datapath mux handles this).
- MEMORY: `memread` (load) or `memwrite` (store) held until `mem_ack`. On ack: load -> WRITEBACK; store -> FETCH with pc += 4.
- WRITEBACK: `regwr`=1 for exactly one cycle; pc += 4 unless jal -> FETCH.
- HALTED: absorbing. Only reset leaves it. `start` is ignored.
- PC arithmetic is modulo 2^32. Immediates are sign-extended. Bits [1:0] are forced to 0.

## Timing
- Reset (async assert, sync deassert inside the block): state IDLE, `pc`=PC_RESET, `instruction`=0, all strobes 0, `busy`=0, `halted`=0, `illegal`=0.
- Outputs are Moore, registered from state. There is no combinational path from input to output.
- Minimum cycles per instruction, with zero-wait memories: branch 3, ALU/lui/jal 4, store 4, load 5.
- Each cycle of `imem_valid` or `mem_ack` low adds one stall cycle. The strobe stays asserted and the PC is unchanged.
- `imem_valid` asserted in the same cycle FETCH is entered is accepted immediately.
- `ir_load` and `regwr` are single-cycle pulses. `memread` and `memwrite` are never both high.
- Reset mid-instruction aborts it. A partially stalled store has no required completion.

## Configuration
- `SEQ_PERF_COUNTERS_EN` defined: adds outputs `cycle_count[31:0]` and `retired_count[31:0]`.
  - `cycle_count` counts every cycle where `busy`=1.
  - `retired_count` increments on each transition back to FETCH.
  - Both reset to 0, wrap at 2^32, and freeze in HALTED.
- Not defined: these ports and their logic are absent.

## Test plan
- Reset with PC_RESET=32'h100 -> `pc`=32'h100, IDLE, all strobes 0. `start`, then add x1,x2,x3 with zero-wait memories -> `regwr` high in cycle 4, `pc`=32'h104.
- Load with `mem_ack` delayed 3 cycles -> `memread` high for 4 cycles, `regwr` pulse after the ack, 8 cycles total.
- beq with `zero`=1 and offset +16 at pc 32'h200 -> `pc`=32'h210. bne with `zero`=1 -> `pc`=32'h204.
- ecall (32'h00000073) -> `halted`=1, `illegal`=0, no further `imem_req` even with `start` pulsed. Opcode 7'b1111111 -> `halted`=1, `illegal`=1.
- Assert `rst` low during a MEMORY stall -> all outputs return to reset values asynchronously, next to IDLE.
- With `SEQ_PERF_COUNTERS_EN`: 3 ALU instructions then ecall -> `retired_count`=3, `cycle_count`=14.
